timer_arb: RTL and testbench
============================

# timer_arb

Round-robin arbiter that shares the register port of one `timer` instance between `NREQ` bus requesters (CPU core, DMA sequencer, debug port). Each requester issues single register reads or writes through a req/ack handshake. The arbiter serialises these onto the timer's `cs`/`addr`/`wen`/`din` port and returns the timer's registered `dout` to the winner. The timer `irq` is fanned out to the requesters.

## Interface
- `WIDTH`, 32, data width; matches the timer.
- `NREQ`, 4, number of requesters, 2..8.
- `IW`, 3, requester index width, ≥ clog2(NREQ).

- `clk`  in  1  single clock, shared with the timer `clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held until `ack`.
- `wen`  in  NREQ  per-requester write enable; 1 = write.
- `addr`  in  3*NREQ  register address; slice i = [3i+2:3i].
- `din`  in  WIDTH*NREQ  write data; slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- `ack`  out  NREQ  one-cycle completion pulse, one-hot.
- `err`  out  1  valid with `ack`; 1 = access rejected.
- `rdata`  out  WIDTH  read data; valid while `ack` is high.
- `irq_out`  out  NREQ  timer interrupt routed to the requesters.
- `t_cs`, `t_wen`  out  1  to timer `cs` and `wen`.
- `t_addr`  out  3  to timer `addr`.
- `t_din`  out  WIDTH  to timer `din`.
- `t_dout`  in  WIDTH  from timer `dout`.
- `t_irq`  in  1  from timer `irq`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK. All outputs are registered.
- **IDLE**
  - If any `req` bit is set, grant the first set bit at or after `ptr`, scanning upward and wrapping modulo NREQ.
  - Latch the winner's index, `wen`, `addr` and `din`.
  - Next state: ISSUE.
- **ISSUE**
  - Drive `t_cs`=1 with the latched `t_wen`, `t_addr` and `t_din` for exactly one cycle.
  - Next state: ACK for a write, CAPTURE for a read.
- **CAPTURE**: latch `t_dout` into `rdata`. Next state: ACK.
- **ACK**
  - Pulse `ack[idx]`=1 for one cycle.
  - Set `ptr` = idx+1 modulo NREQ.
  - Next state: IDLE.
- `rdata` holds its last value outside ACK. For a write ACK, `rdata` reads 0.
- A requester must deassert `req`, or present a new transaction, in the cycle after `ack`. A `req` still high in IDLE is treated as a new transaction.
- Dropping `req` after the grant does not abort the transaction; the `ack` pulse is still issued.
- `t_cs` is 0 in every state except ISSUE. The timer therefore never sees back-to-back `cs`, and each access produces exactly one counter-load edge.
- Without the configuration macro, `irq_out` = {NREQ{t_irq}}, registered.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled.
- Write: `t_cs` high in cycle 1; timer register updated at the end of cycle 1; `ack` in cycle 2.
- Read: `t_cs` high in cycle 1; timer `obuf` valid in cycle 2 and captured; `ack` and `rdata` in cycle 3.
- Throughput: a new grant can occur in the cycle after ACK. This gives 3 cycles per write and 4 per read.
- `irq_out` lags `t_irq` by 1 cycle.
- Reset values: all outputs 0, FSM IDLE, `ptr`=0, owner cleared.
- An asynchronous reset during ISSUE deasserts `t_cs` immediately. No `ack` is issued for the aborted transaction.

## Configuration
- **`TIMER_ARB_OWNER_EN` defined:**
  - The arbiter tracks an owner: a valid bit plus an index.
  - A write to CTRL (addr 0) with `din[0]`=1 while no owner is set claims ownership for that requester.
  - A write to CTRL with `din[0]`=0 by the owner releases ownership.
  - While an owner is set, any non-owner write to addr 0..3 skips ISSUE (`t_cs` stays 0). It goes directly to ACK with `err`=1.
  - Reads and STAT writes (addr 4) are accepted from any requester.
  - `irq_out` is raised only on the owner's bit; all bits are 0 when there is no owner.
- **Not defined:**
  - All accesses are accepted and `err` is constantly 0.
  - `irq_out` is broadcast to all requesters.
  - No owner state is built.

## Test plan
- **Single write.** Requester 0 writes PSCR=0x05. Required: `t_cs` high for exactly 1 cycle with `t_addr`=1 and `t_din`=5; `ack[0]` in cycle 2. A subsequent read of addr 1 returns `rdata`=0x05 with `ack[0]` in cycle 3.
- **Round-robin.** All 4 `req` held high with reads of addr 2. Required grant order 0,1,2,3,0; each `ack` 4 cycles apart; no `t_cs` pulses in adjacent cycles.
- **Pointer wrap.** After a grant to requester 3, requesters 0 and 2 request simultaneously. Required: requester 0 is granted first.
- **Reset mid-access.** `reset_n` is pulled low during ISSUE of a CNTR write. Required: `t_cs`=0 asynchronously; no `ack`; `ptr`=0 after release.
- **Ownership (macro on).**
  - Requester 1 writes CTRL=0x3 and claims ownership.
  - Requester 2 writes AR=0x10. Required: `err`=1, no `t_cs`, AR unchanged.
  - Requester 2 reads STAT. Required: `err`=0.
  - `t_irq`=1. Required: `irq_out`=4'b0010.
- **IRQ broadcast (macro off).** `t_irq`=1. Required: `irq_out`=4'hF one cycle later, and `err`=0 on every `ack`.

Source files
------------

// File: rtl/timer_arb_if.sv
// Requester-side bus of timer_arb: per-requester request slices and shared completion signals.
// The master modport is the requester side and the slave modport is the arbiter side.
interface timer_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wen;
  logic [3*NREQ-1:0]     addr;
  logic [WIDTH*NREQ-1:0] din;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [WIDTH-1:0]      rdata;
  logic [NREQ-1:0]       irq_out;

  modport master (
    output req, wen, addr, din,
    input  ack, err, rdata, irq_out
  );

  modport slave (
    input  req, wen, addr, din,
    output ack, err, rdata, irq_out
  );
endinterface

// File: rtl/timer_arb.sv
// Round-robin arbiter that serialises NREQ requesters onto one timer register port.
// Define TIMER_ARB_OWNER_EN to add CTRL-write ownership with access rejection and owner-only irq.
module timer_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  timer_arb_if.slave       bus,
  output logic             t_cs,
  output logic             t_wen,
  output logic [2:0]       t_addr,
  output logic [WIDTH-1:0] t_din,
  input  logic [WIDTH-1:0] t_dout,
  input  logic             t_irq
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wen_q, wen_d;
  logic [2:0]       addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             t_cs_q, t_cs_d;
  logic             t_wen_q, t_wen_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]  irq_q, irq_d;
  logic             go_ack;
  logic             reject;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_wen;
  logic [2:0]       gnt_addr;
  logic [WIDTH-1:0] gnt_din;

  // Requesters at or above ptr win first; the second pass covers the wrap below ptr.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_wen  = 1'b0;
    gnt_addr = '0;
    gnt_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && bus.req[i] && (IW'(i) >= ptr_q)) begin
        gnt_vld  = 1'b1;
        gnt_idx  = IW'(i);
        gnt_wen  = bus.wen[i];
        gnt_addr = bus.addr[3*i +: 3];
        gnt_din  = bus.din[WIDTH*i +: WIDTH];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && bus.req[i]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = IW'(i);
        gnt_wen  = bus.wen[i];
        gnt_addr = bus.addr[3*i +: 3];
        gnt_din  = bus.din[WIDTH*i +: WIDTH];
      end
    end
  end

`ifdef TIMER_ARB_OWNER_EN
  logic          own_vld_q, own_vld_d;
  logic [IW-1:0] own_idx_q, own_idx_d;

  // Only control-register writes from someone other than the current owner are refused.
  assign reject = own_vld_q && gnt_wen && (gnt_addr < 3'd4) && (gnt_idx != own_idx_q);

  always_comb begin
    own_vld_d = own_vld_q;
    own_idx_d = own_idx_q;
    if ((state_q == IDLE) && gnt_vld && gnt_wen && !reject && (gnt_addr == 3'd0)) begin
      if (gnt_din[0] && !own_vld_q) begin
        own_vld_d = 1'b1;
        own_idx_d = gnt_idx;
      end else if (!gnt_din[0] && own_vld_q && (own_idx_q == gnt_idx)) begin
        own_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    irq_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      irq_d[i] = t_irq && own_vld_q && (own_idx_q == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else begin
      own_vld_q <= own_vld_d;
      own_idx_q <= own_idx_d;
    end
  end
`else
  assign reject = 1'b0;

  always_comb begin
    irq_d = {NREQ{t_irq}};
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    t_cs_d  = 1'b0;
    t_wen_d = 1'b0;
    err_d   = 1'b0;
    go_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          idx_d = gnt_idx;
          wen_d = gnt_wen;
          if (reject) begin
            state_d = ACK;
            go_ack  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d  = gnt_addr;
            din_d   = gnt_din;
            state_d = ISSUE;
            t_cs_d  = 1'b1;
            t_wen_d = gnt_wen;
          end
        end
      end
      ISSUE: begin
        if (wen_q) begin
          state_d = ACK;
          go_ack  = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // The timer registers dout, so the value for the ISSUE cycle appears here.
        rdata_d = t_dout;
        state_d = ACK;
        go_ack  = 1'b1;
      end
      ACK: begin
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_d[i] = go_ack && (idx_d == IW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      t_cs_q  <= 1'b0;
      t_wen_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      t_cs_q  <= t_cs_d;
      t_wen_q <= t_wen_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign t_cs        = t_cs_q;
  assign t_wen       = t_wen_q;
  assign t_addr      = addr_q;
  assign t_din       = din_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.irq_out = irq_q;

endmodule

// File: tb/tb_timer_arb.sv
// Self-checking bench for timer_arb: a table of single transactions plus hand-written multi-cycle
// sequences, with a behavioural timer register file and an ack scoreboard.
module tb_timer_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam logic [2:0] CTRL = 3'd0, PSCR = 3'd1, CNTR = 3'd2, AR = 3'd3, STAT = 4'd4;

`ifdef TIMER_ARB_OWNER_EN
  localparam logic [3:0] IRQ_NO_OWNER = 4'h0;
`else
  localparam logic [3:0] IRQ_NO_OWNER = 4'hF;
`endif

  typedef struct {
    int          idx;
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          ncs;
  } vec_t;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             t_cs, t_wen, t_irq;
  logic [2:0]       t_addr;
  logic [WIDTH-1:0] t_din;
  logic [WIDTH-1:0] t_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  exp_t        sb[$];
  logic [31:0] tregs[8];
  int          cs_cnt = 0;
  logic        cs_prev = 1'b0;
  logic [2:0]  cs_addr = '0;
  logic [31:0] cs_din = '0;

  timer_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  timer_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .t_cs    (t_cs),
    .t_wen   (t_wen),
    .t_addr  (t_addr),
    .t_din   (t_din),
    .t_dout  (t_dout),
    .t_irq   (t_irq)
  );

  always #5 clk = ~clk;

  // Behavioural timer register port: writes land at the edge, reads come back registered.
  always @(posedge clk) begin
    if (t_cs) begin
      if (t_wen) tregs[t_addr] <= t_din;
      else       t_dout <= tregs[t_addr];
    end
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and t_cs monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack != '0) begin
      check(sb.size() != 0, "ack_expected", 64'(bus.ack), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(bus.ack == (4'b0001 << e.idx), "ack_onehot", 64'(bus.ack), 64'(4'b0001 << e.idx));
        check(bus.err == e.err, "ack_err", 64'(bus.err), 64'(e.err));
        check(bus.rdata == e.rd, "ack_rdata", 64'(bus.rdata), 64'(e.rd));
      end
    end
    if (t_cs) begin
      check(!cs_prev, "tcs_back_to_back", 64'(cs_prev), 64'd0);
      cs_cnt++;
      cs_addr = t_addr;
      cs_din  = t_din;
    end
    cs_prev = t_cs;
  end

  task automatic set_slot(input int i, input logic w, input logic [2:0] a, input logic [31:0] d);
    bus.wen[i]           = w;
    bus.addr[3*i +: 3]   = a;
    bus.din[WIDTH*i +: WIDTH] = d;
  endtask

  task automatic do_txn(input vec_t v);
    int   n;
    int   cs0;
    bit   got;
    exp_t e;
    @(negedge clk);
    set_slot(v.idx, v.w, v.a, v.d);
    e.idx = v.idx; e.err = v.err; e.rd = v.rd;
    sb.push_back(e);
    cs0 = cs_cnt;
    bus.req[v.idx] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.ack != '0) got = 1;
    end
    bus.req[v.idx] = 1'b0;
    check(got, "txn_ack_seen", 64'(got), 64'd1);
    check(n == v.lat, "txn_latency", 64'(n), 64'(v.lat));
    check(cs_cnt - cs0 == v.ncs, "txn_cs_cycles", 64'(cs_cnt - cs0), 64'(v.ncs));
    if (v.ncs != 0) begin
      check(cs_addr == v.a, "txn_t_addr", 64'(cs_addr), 64'(v.a));
      if (v.w) check(cs_din == v.d, "txn_t_din", 64'(cs_din), 64'(v.d));
    end
  endtask

  // Holds several requests; optionally drops each one as it is acked, all once n_acks are seen.
  task automatic run_multi(input logic [3:0] mask, input int n_acks, input bit drop_each, input int gap);
    int seen = 0;
    int t = 0;
    int last_t = -1;
    @(negedge clk);
    bus.req = mask;
    while (seen < n_acks && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.ack != '0) begin
        if (last_t >= 0 && gap > 0) check(t - last_t == gap, "ack_gap", 64'(t - last_t), 64'(gap));
        last_t = t;
        seen++;
        if (drop_each) bus.req = bus.req & ~bus.ack;
        if (seen == n_acks) bus.req = '0;
      end
    end
    bus.req = '0;
    check(seen == n_acks, "multi_ack_count", 64'(seen), 64'(n_acks));
  endtask

  task automatic push_exp(input int i, input logic err, input logic [31:0] rd);
    exp_t e;
    e.idx = i; e.err = err; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) tregs[i] = '0;
    bus.req = '0; bus.wen = '0; bus.addr = '0; bus.din = '0;
    t_irq = 1'b0;

    tbl[0] = '{0, 1'b1, PSCR, 32'h0000_0005, 32'h0,         1'b0, 2, 1};
    tbl[1] = '{0, 1'b0, PSCR, 32'h0,         32'h0000_0005, 1'b0, 3, 1};
    tbl[2] = '{1, 1'b1, CNTR, 32'h0000_1234, 32'h0,         1'b0, 2, 1};
    tbl[3] = '{2, 1'b0, CNTR, 32'h0,         32'h0000_1234, 1'b0, 3, 1};
    tbl[4] = '{3, 1'b1, AR,   32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1};
    tbl[5] = '{1, 1'b0, AR,   32'h0,         32'hDEAD_BEEF, 1'b0, 3, 1};
    tbl[6] = '{2, 1'b1, STAT, 32'h0000_00A5, 32'h0,         1'b0, 2, 1};
    tbl[7] = '{3, 1'b0, STAT, 32'h0,         32'h0000_00A5, 1'b0, 3, 1};
    tbl[8] = '{0, 1'b0, 3'd7, 32'h0,         32'h0,         1'b0, 3, 1};

    repeat (3) @(negedge clk);
    check(t_cs == 1'b0 && t_wen == 1'b0, "reset_t_cs_wen", {t_cs, t_wen}, 64'd0);
    check(t_addr == '0 && t_din == '0, "reset_t_addr_din", {t_addr, t_din}, 64'd0);
    check(bus.ack == '0 && bus.err == 1'b0, "reset_ack_err", {bus.ack, bus.err}, 64'd0);
    check(bus.rdata == '0 && bus.irq_out == '0, "reset_rdata_irq", {bus.rdata, bus.irq_out}, 64'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++) do_txn(tbl[k]);

    // irq_out is registered: unchanged right after t_irq rises, updated one cycle later.
    @(negedge clk);
    t_irq = 1'b1;
    #1 check(bus.irq_out == 4'h0, "irq_not_yet", 64'(bus.irq_out), 64'h0);
    @(negedge clk);
    check(bus.irq_out == IRQ_NO_OWNER, "irq_no_owner", 64'(bus.irq_out), 64'(IRQ_NO_OWNER));
    t_irq = 1'b0;
    repeat (2) @(negedge clk);
    check(bus.irq_out == 4'h0, "irq_low", 64'(bus.irq_out), 64'h0);

`ifdef TIMER_ARB_OWNER_EN
    v = '{1, 1'b1, CTRL, 32'h3, 32'h0, 1'b0, 2, 1};          do_txn(v);
    v = '{2, 1'b1, AR, 32'h10, 32'h0, 1'b1, 1, 0};           do_txn(v);
    v = '{2, 1'b0, AR, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1};    do_txn(v);
    v = '{2, 1'b0, STAT, 32'h0, 32'h0000_00A5, 1'b0, 3, 1};  do_txn(v);
    v = '{2, 1'b1, STAT, 32'h77, 32'h0, 1'b0, 2, 1};         do_txn(v);
    @(negedge clk);
    t_irq = 1'b1;
    repeat (2) @(negedge clk);
    check(bus.irq_out == 4'b0010, "irq_owner_only", 64'(bus.irq_out), 64'h2);
    v = '{1, 1'b1, CTRL, 32'h0, 32'h0, 1'b0, 2, 1};          do_txn(v);
    repeat (2) @(negedge clk);
    check(bus.irq_out == 4'h0, "irq_after_release", 64'(bus.irq_out), 64'h0);
    t_irq = 1'b0;
    v = '{2, 1'b1, STAT, 32'hA5, 32'h0, 1'b0, 2, 1};         do_txn(v);
`endif

    // Round robin from a fresh pointer: all four read CNTR, order 0,1,2,3,0, 4 cycles apart.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_slot(i, 1'b0, CNTR, 32'h0);
    push_exp(0, 1'b0, 32'h1234);
    push_exp(1, 1'b0, 32'h1234);
    push_exp(2, 1'b0, 32'h1234);
    push_exp(3, 1'b0, 32'h1234);
    push_exp(0, 1'b0, 32'h1234);
    run_multi(4'hF, 5, 1'b0, 4);

    // Pointer wrap: after a grant to 3, requesters 0 and 2 together must go 0 first.
    v = '{3, 1'b0, STAT, 32'h0, 32'h0000_00A5, 1'b0, 3, 1};
    do_txn(v);
    set_slot(0, 1'b0, CNTR, 32'h0);
    set_slot(2, 1'b0, PSCR, 32'h0);
    push_exp(0, 1'b0, 32'h1234);
    push_exp(2, 1'b0, 32'h5);
    run_multi(4'b0101, 2, 1'b1, 0);

    // Reset while a CNTR write is in ISSUE: t_cs drops at once, no ack, register untouched.
    @(negedge clk);
    set_slot(0, 1'b1, CNTR, 32'h0000_0BAD);
    bus.req[0] = 1'b1;
    @(negedge clk);
    check(t_cs == 1'b1, "issue_before_reset", 64'(t_cs), 64'd1);
    #2 reset_n = 1'b0;
    #1 check(t_cs == 1'b0, "t_cs_async_clear", 64'(t_cs), 64'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check(sb.size() == 0, "no_pending_ack", 64'(sb.size()), 64'd0);

    // Pointer must restart at 0: requesters 0 and 3 together go 0 first.
    set_slot(0, 1'b0, CNTR, 32'h0);
    set_slot(3, 1'b0, STAT, 32'h0);
    push_exp(0, 1'b0, 32'h1234);
    push_exp(3, 1'b0, 32'hA5);
    run_multi(4'b1001, 2, 1'b1, 0);

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
